// File: rtl/uart_pkg.sv
// Shared UART constants and rx state encoding (also used by uart_tx).
// Optional macro UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int UART_T_DIV_BIT    = 13;
    localparam int UART_T_DIV_0      = 5207;  // 9600 baud at 50 MHz
    localparam int UART_T_DIV_HALF_0 = 2603;
    localparam int UART_T_DIV_1      = 2603;  // 19200 baud at 50 MHz
    localparam int UART_T_DIV_HALF_1 = 1301;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        , RX_PARITY  = 3'd5
`endif
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (line idle).
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 at 9600/19200 baud with mid-bit sampling.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int T_DIV_BIT    = UART_T_DIV_BIT,
    parameter int T_DIV_0      = UART_T_DIV_0,
    parameter int T_DIV_HALF_0 = UART_T_DIV_HALF_0,
    parameter int T_DIV_1      = UART_T_DIV_1,
    parameter int T_DIV_HALF_1 = UART_T_DIV_HALF_1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baudrate,
    input  logic       uart_rxd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    rx_state_t              r_state;
    logic [T_DIV_BIT-1:0]   r_cnt;
    logic [2:0]             r_bitn;
    logic [7:0]             r_shift;
    logic [7:0]             r_dout;
    logic                   r_rate;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   w_rxd_s;
    logic [T_DIV_BIT-1:0]   w_full;
    logic [T_DIV_BIT-1:0]   w_half;
    logic                   w_tick;
`ifdef UART_RX_PARITY_EN
    logic                   r_par;
    logic                   r_perr;
`endif

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (uart_rxd),
        .o_q (w_rxd_s)
    );

    // Rate is latched at the start edge so a mid-frame change is ignored.
    assign w_full = r_rate ? T_DIV_BIT'(T_DIV_1)      : T_DIV_BIT'(T_DIV_0);
    assign w_half = r_rate ? T_DIV_BIT'(T_DIV_HALF_1) : T_DIV_BIT'(T_DIV_HALF_0);
    assign w_tick = (r_cnt == w_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_rate  <= 1'b0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                RX_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                        r_rate  <= baudrate;
                    end
                end
                RX_START: begin
                    if (r_cnt == w_half) begin
                        r_cnt   <= '0;
                        r_bitn  <= '0;
                        r_state <= w_rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxd_s, r_shift[7:1]};
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_par   <= w_rxd_s;
                        r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_rxd_s) begin
                            r_dout  <= r_shift;
                            r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_perr  <= r_par ^ (^r_shift);
`endif
                            r_state <= RX_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= RX_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Hold off until the line is released so a break reports once.
                RX_WAIT_IDLE: begin
                    if (w_rxd_s) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != RX_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a monitor pops on pulses.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       baudrate;
    logic       uart_rxd;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(
        .T_DIV_BIT    (13),
        .T_DIV_0      (15),
        .T_DIV_HALF_0 (7),
        .T_DIV_1      (7),
        .T_DIV_HALF_1 (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baudrate  (baudrate),
        .uart_rxd  (uart_rxd),
        .dout      (dout),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errs   = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a frame yields a byte if its stop bit is high, else a frame error
    // that leaves the last good byte on dout.
    task automatic send_frame(input logic [7:0] b, input logic rate, input logic stop, input logic pbit);
        int   bc;
        exp_t e;
        bc = rate ? 8 : 16;
        e.ferr = ~stop;
        e.perr = pbit ^ (^b);
        if (stop) begin
            e.data    = b;
            last_good = b;
        end else begin
            e.data = last_good;
        end
        sb.push_back(e);
        baudrate = rate;
        uart_rxd = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (bc) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = pbit;
        repeat (bc) @(negedge clk);
`endif
        uart_rxd = stop;
        repeat (bc) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    always @(negedge clk) begin
        if (valid || frame_err) begin
            check("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b dout=%0h expected none",
                         valid, frame_err, dout);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, mon_e.ferr});
                check("dout", {24'd0, dout}, {24'd0, mon_e.data});
`ifdef UART_RX_PARITY_EN
                if (valid) check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
`endif
            end
        end
`ifdef UART_RX_PARITY_EN
        if (parity_err && !valid) begin
            n_checks++;
            n_errs++;
            $display("FAIL parity_without_valid: got parity_err=1 expected 0");
        end
`endif
    end

    task automatic drained(input string name);
        check(name, sb.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rr;
        logic       rs;
        rst      = 1'b1;
        baudrate = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout",  {24'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte at 9600
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        drained("a5_pulse");
        check("a5_dout", {24'd0, dout}, 32'hA5);
        check("a5_busy", {31'd0, busy}, 32'd0);

        // Back-to-back at 19200
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        drained("b2b_pulses");
        check("b2b_dout", {24'd0, dout}, 32'hC3);

        // Short glitch on the line is rejected
        baudrate = 1'b0;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_dout", {24'd0, dout}, 32'hC3);

        // Bad stop bit followed by a long break
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        repeat (50) @(negedge clk);
        check("break_busy_a", {31'd0, busy}, 32'd1);
        repeat (50) @(negedge clk);
        check("break_busy_b", {31'd0, busy}, 32'd1);
        drained("break_one_ferr");
        check("break_dout", {24'd0, dout}, 32'hC3);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("break_release_busy", {31'd0, busy}, 32'd0);

        // Rate change mid-frame must not disturb reception
        fork
            send_frame(8'h96, 1'b1, 1'b1, 1'b0);
            begin
                repeat (30) @(negedge clk);
                baudrate = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        drained("rate_change");

        // Reset during bit 4 of 8'hFF
        baudrate = 1'b0;
        uart_rxd = 1'b0;
        repeat (16) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4 * 16 + 8) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dout",  {24'd0, dout}, 32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (40) @(negedge clk);
        drained("mid_rst_no_pulse");
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        drained("post_rst_pulse");
        check("post_rst_dout", {24'd0, dout}, 32'h12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        drained("parity_pulses");
`endif

        // Randomized frames, rates, stop bits and gaps
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom);
            rr = 1'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            send_frame(rb, rr, rs, 1'($urandom));
            repeat ($urandom_range(4, 20)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        drained("random_all_seen");
        check("random_busy", {31'd0, busy}, 32'd0);
        check("random_dout", {24'd0, dout}, {24'd0, last_good});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
